// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
package inst_fetch_pkg;

  localparam int AddrBus = 64;
  localparam int InstBus = 32;

  localparam logic [AddrBus-1:0] ResetPcDef = 64'h0000_0000_8000_0000;

  // Major opcodes, shared with decode.
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage.
module fetch_fifo #(
  parameter int Width    = 96,
  parameter int Depth    = 4,
  parameter int CntWidth = $clog2(Depth) + 1
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic [Width-1:0]    wdata,
  output logic [Width-1:0]    rdata,
  output logic                full,
  output logic                empty,
  output logic [CntWidth-1:0] count
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                 (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign count = CntWidth'(wptr_q - rptr_q);
  assign rdata = mem_q[rptr_q[PtrW-1:0]];

  // Pointer update; flush discards every entry.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push && !full) wptr_q <= wptr_q + 1'b1;
      if (pop && !empty) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents are only observed behind a valid pointer.
  always_ff @(posedge Clk) begin
    if (push && !full && !flush) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

  // Callers size their traffic so this can never happen.
  a_no_overflow: assert property (@(posedge Clk) disable iff (!RstN) !(push && full));

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, request issue, in-order response buffering, redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [63:0] ResetPc   = ResetPcDef,
  parameter int          FifoDepth = 4,
  parameter int          CntWidth  = $clog2(FifoDepth) + 1
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        RedirectValid,
  input  logic [63:0] RedirectPc,
  output logic        IMemReqValid,
  output logic [63:0] IMemReqAddr,
  input  logic        IMemReqReady,
  input  logic        IMemRespValid,
  input  logic [31:0] IMemRespData,
  output logic        InstValid,
  output logic [63:0] InstAddrOut,
  output logic [31:0] InstOut,
  input  logic        IdReady
);

  fetch_state_e        state_q, state_d;
  logic [63:0]         pc_q, pc_d;
  logic [CntWidth-1:0] inflight_q, inflight_d;
  logic [CntWidth-1:0] drop_q, drop_d;

  logic                run, pop_raw, pop, fire, resp, keep, flush;
  logic [CntWidth:0]   occ;
  logic [95:0]         head;
  logic [63:0]         tag;
  logic [CntWidth-1:0] count, tag_count;
  logic                empty, full, tag_full, tag_empty;
  logic                unused_ok;

  assign run     = (state_q == RUN);
  assign InstValid = run & ~empty;
  assign pop_raw = InstValid & IdReady;
  // Decode flushes alongside us on a redirect, so its pop is ignored then.
  assign pop     = pop_raw & ~RedirectValid;
  assign flush   = run & RedirectValid;
  assign resp    = run & IMemRespValid;
  // Responses issued before a redirect (including one arriving with it) are stale.
  assign keep    = resp & ~RedirectValid & (drop_q == '0);
  assign fire    = IMemReqValid & IMemReqReady;

  // Outstanding plus buffered work must stay within the buffer so no push can overflow.
  assign occ = {1'b0, inflight_q} + {1'b0, count} - {{CntWidth{1'b0}}, pop_raw};
  assign IMemReqValid = run & ~RedirectValid & (occ < (CntWidth+1)'(FifoDepth));
  assign IMemReqAddr  = pc_q;

  assign InstAddrOut = InstValid ? head[95:32] : '0;
  assign InstOut     = InstValid ? head[31:0]  : '0;

  assign unused_ok = ^{full, tag_full, tag_empty, tag_count};

  // Next-state: one BOOT cycle, then PC, in-flight and drop bookkeeping in RUN.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        state_d    = RUN;
        inflight_d = inflight_q + CntWidth'(fire) - CntWidth'(resp);
        if (fire) pc_d = pc_q + 64'd4;
        if (RedirectValid) begin
          pc_d   = {RedirectPc[63:2], 2'b00};
          // Everything still outstanding after this cycle is stale; this
          // already covers responses marked stale by earlier redirects.
          drop_d = inflight_q - CntWidth'(resp);
        end else if (resp && drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // State registers.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_q    <= BOOT;
      pc_q       <= ResetPc;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Issued addresses, one per outstanding request; each response consumes one.
  fetch_fifo #(.Width(64), .Depth(FifoDepth), .CntWidth(CntWidth)) u_tag_q (
    .Clk   (Clk),
    .RstN  (RstN),
    .push  (fire),
    .pop   (resp),
    .flush (1'b0),
    .wdata (pc_q),
    .rdata (tag),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  // Instruction buffer presented to decode.
  fetch_fifo #(.Width(96), .Depth(FifoDepth), .CntWidth(CntWidth)) u_inst_q (
    .Clk   (Clk),
    .RstN  (RstN),
    .push  (keep),
    .pop   (pop),
    .flush (flush),
    .wdata ({tag, IMemRespData}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench: memory model + epoch-based reference, scoreboard on the decode side.
module tb_inst_fetch;

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        RedirectValid = 1'b0;
  logic [63:0] RedirectPc = '0;
  logic        IMemReqValid;
  logic [63:0] IMemReqAddr;
  logic        IMemReqReady = 1'b0;
  logic        IMemRespValid = 1'b0;
  logic [31:0] IMemRespData = '0;
  logic        InstValid;
  logic [63:0] InstAddrOut;
  logic [31:0] InstOut;
  logic        IdReady = 1'b0;

  inst_fetch dut (
    .Clk           (Clk),
    .RstN          (RstN),
    .RedirectValid (RedirectValid),
    .RedirectPc    (RedirectPc),
    .IMemReqValid  (IMemReqValid),
    .IMemReqAddr   (IMemReqAddr),
    .IMemReqReady  (IMemReqReady),
    .IMemRespValid (IMemRespValid),
    .IMemRespData  (IMemRespData),
    .InstValid     (InstValid),
    .InstAddrOut   (InstAddrOut),
    .InstOut       (InstOut),
    .IdReady       (IdReady)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        pend[$];     // requests accepted by memory, in order
  logic [95:0] exp_q[$];    // instructions decode should see, in order
  logic [63:0] pc;
  int          epoch, cyc, last_due;
  bit          boot;
  int          checks, errors;
  int          lat, id_pct, rdy_pct, redir_pct;
  bit          force_redir, redir_on_resp;
  logic [63:0] force_pc;

  function automatic logic [31:0] mdata(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode-side monitor: compares the presented head against the scoreboard.
  task automatic mon();
    if (!RstN) return;
    if (InstValid && !RedirectValid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL inst_out: got unexpected %h/%h, expected nothing (cycle %0d)",
                 InstAddrOut, InstOut, cyc);
      end else begin
        chk("inst_out", {InstAddrOut, InstOut}, exp_q[0]);
        if (IdReady) void'(exp_q.pop_front());
      end
    end
  endtask

  // One clock cycle: drive inputs, check request side, advance the reference.
  task automatic step();
    bit   redir_in, redir, resp, fire, exp_rv, exp_iv;
    logic [63:0] rpc;
    int   busy, d;
    req_t r;
    @(negedge Clk);
    IdReady      = ($urandom_range(99) < id_pct);
    IMemReqReady = ($urandom_range(99) < rdy_pct);
    resp = (pend.size() > 0) && (pend[0].due <= cyc);
    IMemRespValid = resp;
    IMemRespData  = '0;
    if (resp) IMemRespData = mdata(pend[0].addr);
    if (boot) redir_in = ($urandom_range(1) == 1);
    else redir_in = force_redir || (redir_on_resp && resp) || ($urandom_range(99) < redir_pct);
    redir = redir_in && !boot;
    rpc = force_redir ? force_pc : {$urandom, $urandom};
    if (redir) begin
      force_redir   = 1'b0;
      redir_on_resp = 1'b0;
    end
    RedirectValid = redir_in;
    RedirectPc    = rpc;
    #1;
    exp_iv = !boot && (exp_q.size() > 0);
    busy   = pend.size() + exp_q.size() - ((exp_iv && IdReady) ? 1 : 0);
    exp_rv = !boot && !redir && (busy < 4);
    chk("inst_valid", 96'(InstValid), 96'(exp_iv));
    chk("req_valid", 96'(IMemReqValid), 96'(exp_rv));
    if (exp_rv) chk("req_addr", 96'(IMemReqAddr), 96'(pc));
    fire = exp_rv && IMemReqReady;
    if (resp) begin
      r = pend.pop_front();
      if (!redir && r.epoch == epoch) exp_q.push_back({r.addr, mdata(r.addr)});
    end
    if (fire) begin
      d = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      pend.push_back('{addr: pc, epoch: epoch, due: d});
      last_due = d;
      pc = pc + 64'd4;
    end
    if (redir) begin
      exp_q.delete();
      epoch++;
      pc = {rpc[63:2], 2'b00};
    end
    boot = 1'b0;
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    @(negedge Clk);
    #3;
    RstN = 1'b0;
    #1;
    chk("rst_req_valid", 96'(IMemReqValid), 96'(0));
    chk("rst_inst_valid", 96'(InstValid), 96'(0));
    chk("rst_inst_addr", 96'(InstAddrOut), 96'(0));
    chk("rst_inst", 96'(InstOut), 96'(0));
    RedirectValid = 1'b0;
    IMemRespValid = 1'b0;
    IMemReqReady  = 1'b0;
    IdReady       = 1'b0;
    pend.delete();
    exp_q.delete();
    pc       = 64'h0000_0000_8000_0000;
    epoch    = 0;
    last_due = 0;
    boot     = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    RstN = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    lat = 1; id_pct = 100; rdy_pct = 100; redir_pct = 0;
    force_redir = 1'b0; redir_on_resp = 1'b0; force_pc = '0;
    fork
      forever begin
        @(negedge Clk);
        #2;
        mon();
      end
    join_none

    // Streaming with a 1-cycle memory.
    do_reset();
    repeat (20) step();

    // Decode stall fills the buffer, then drains in order.
    id_pct = 0;
    repeat (10) step();
    id_pct = 100;
    repeat (12) step();

    // 3-cycle memory, redirect to an unaligned target with requests in flight.
    lat = 3;
    repeat (6) step();
    force_pc = 64'h0000_0000_8000_1003;
    force_redir = 1'b1;
    repeat (14) step();

    // Redirect coinciding with a stale response.
    lat = 2;
    repeat (3) begin
      redir_on_resp = 1'b1;
      repeat (8) step();
    end

    // Random ready, stalls, latency and redirects.
    repeat (8) begin
      lat       = $urandom_range(4, 1);
      id_pct    = $urandom_range(100, 30);
      rdy_pct   = $urandom_range(100, 30);
      redir_pct = 5;
      repeat (50) step();
    end
    redir_pct = 0;

    // Reset with a partly filled buffer, then restart.
    lat = 1; id_pct = 0; rdy_pct = 100;
    repeat (4) step();
    do_reset();
    id_pct = 100;
    repeat (10) step();

    // PC wrap at the top of the address space.
    force_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    force_redir = 1'b1;
    repeat (6) step();

    // Drain with no new requests.
    rdy_pct = 0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
